// File: rtl/byte_uart_tx.sv
// Byte-wide UART transmitter (8N1) fed by a small byte FIFO.
// Strobed bytes are queued and sent back to back with no idle gap between frames.
module byte_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   in_byte,
  input  logic                         in_byte_en,
  output logic                         tx,
  output logic                         tx_busy,
  output logic                         fifo_empty,
  output logic                         fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);
  localparam logic [AddrW-1:0] PtrOne = AddrW'(1);
  localparam logic [CntW-1:0]  CntOne = CntW'(1);
  localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            r_state, w_state_d;
  logic [15:0]       r_baud, w_baud_d;
  logic [2:0]        r_bit_cnt, w_bit_cnt_d;
  logic [7:0]        r_shift, w_shift_d;
  logic              r_tx, w_tx_d;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [AddrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count, w_count_d;
  logic              r_full, r_empty, r_overflow;

  logic              w_push, w_pop, w_drop, w_baud_zero;
  logic [7:0]        w_head;

  // Full/empty come from registered flags, so a pop in the same cycle never frees a slot.
  assign w_push      = in_byte_en && !r_full && !reset;
  assign w_drop      = in_byte_en && r_full;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_zero = (r_baud == 16'd0);

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CntOne;
      2'b01:   w_count_d = r_count - CntOne;
      default: w_count_d = r_count;
    endcase
  end

  always_comb begin
    w_state_d   = r_state;
    w_baud_d    = r_baud;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_tx_d      = r_tx;
    w_pop       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_tx_d = 1'b1;
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_shift_d   = w_head;
          w_bit_cnt_d = 3'd0;
          w_baud_d    = BaudMax;
          w_state_d   = StStart;
          w_tx_d      = 1'b0;
        end
      end
      StStart: begin
        if (w_baud_zero) begin
          w_baud_d  = BaudMax;
          w_state_d = StData;
          w_tx_d    = r_shift[0];
        end else begin
          w_baud_d = r_baud - 16'd1;
        end
      end
      StData: begin
        if (w_baud_zero) begin
          w_baud_d = BaudMax;
          if (r_bit_cnt == 3'd7) begin
            w_state_d = StStop;
            w_tx_d    = 1'b1;
          end else begin
            w_bit_cnt_d = r_bit_cnt + 3'd1;
            w_shift_d   = {1'b0, r_shift[7:1]};
            w_tx_d      = r_shift[1];
          end
        end else begin
          w_baud_d = r_baud - 16'd1;
        end
      end
      StStop: begin
        if (w_baud_zero) begin
          // Chain straight into the next start bit when more data is queued.
          if (!r_empty) begin
            w_pop       = 1'b1;
            w_shift_d   = w_head;
            w_bit_cnt_d = 3'd0;
            w_baud_d    = BaudMax;
            w_state_d   = StStart;
            w_tx_d      = 1'b0;
          end else begin
            w_state_d = StIdle;
            w_tx_d    = 1'b1;
          end
        end else begin
          w_baud_d = r_baud - 16'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_baud     <= 16'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_tx       <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_baud     <= w_baud_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_shift    <= w_shift_d;
      r_tx       <= w_tx_d;
      r_count    <= w_count_d;
      r_full     <= (w_count_d == CntFull);
      r_empty    <= (w_count_d == '0);
      r_overflow <= r_overflow | w_drop;
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_byte;
  end

  assign tx         = r_tx;
  assign tx_busy    = (r_state != StIdle);
  assign fifo_empty = r_empty;
  assign fifo_full  = r_full;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule
